// File: rtl/cond_addsub_pipe_if.sv
// Operand/result stream bundle for cond_addsub_pipe: input pair handshake,
// result handshake, and the overflow/count status side-band.
interface cond_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             sub_sel;
    logic             ovf;
    logic             ovf_sticky;
    logic             clr_sticky;
    logic [31:0]      op_count;

    modport master (
        output in_valid, a, b, out_ready, clr_sticky,
        input  in_ready, out_valid, sum, sub_sel, ovf, ovf_sticky, op_count
    );

    modport slave (
        input  in_valid, a, b, out_ready, clr_sticky,
        output in_ready, out_valid, sum, sub_sel, ovf, ovf_sticky, op_count
    );
endinterface

// File: rtl/cond_addsub_pipe.sv
// Two-stage conditional add/subtract with valid/ready flow control,
// optional saturation, sticky overflow and a delivered-result counter.
module cond_addsub_pipe #(
    parameter int WIDTH    = 32,
    parameter int A_MIN    = 2,
    parameter int B_MAX    = 10,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    cond_addsub_pipe_if.slave    bus
);
    localparam logic [WIDTH-1:0] A_MIN_W = WIDTH'(A_MIN);
    localparam logic [WIDTH-1:0] B_MAX_W = WIDTH'(B_MAX);

    function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sub);
        if (sub) return {1'b0, x} - {1'b0, y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Bit WIDTH of the raw result is carry (add) or borrow (sub).
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] r,
                                                  input logic           sub);
        if (SATURATE != 0 && r[WIDTH]) return sub ? '0 : '1;
        return r[WIDTH-1:0];
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             sub_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] sum_p2;
    logic             sub_sel_p2;
    logic             ovf_p2;

    logic             ovf_sticky;
    logic [31:0]      op_count;

    logic             s2_en;
    logic             accept;
    logic             out_xfer;
    logic             add_pred;
    logic [WIDTH:0]   res_p1;

    assign s2_en       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !rst && (!vld_p1 || s2_en);
    assign accept      = bus.in_valid && bus.in_ready;
    assign out_xfer    = vld_p2 && bus.out_ready;
    assign add_pred    = (bus.a >= A_MIN_W) && ((bus.b <= B_MAX_W) || (bus.a == '0));
    assign res_p1      = addsub(a_p1, b_p1, sub_p1);

    // ---- stage 1: capture operands and operation select ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= bus.a;
            b_p1   <= bus.b;
            sub_p1 <= !add_pred;
        end
    end

    // ---- stage 2: arithmetic result, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2     <= 1'b0;
            sum_p2     <= '0;
            sub_sel_p2 <= 1'b0;
            ovf_p2     <= 1'b0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sum_p2     <= saturate(res_p1, sub_p1);
                sub_sel_p2 <= sub_p1;
                ovf_p2     <= res_p1[WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            op_count   <= '0;
        end else begin
            if (out_xfer && ovf_p2) ovf_sticky <= 1'b1;
            else if (bus.clr_sticky) ovf_sticky <= 1'b0;
            if (out_xfer) op_count <= op_count + 32'd1;
        end
    end

    assign bus.out_valid  = vld_p2;
    assign bus.sum        = sum_p2;
    assign bus.sub_sel    = sub_sel_p2;
    assign bus.ovf        = ovf_p2;
    assign bus.ovf_sticky = ovf_sticky;
    assign bus.op_count   = op_count;
endmodule

// File: tb/tb_cond_addsub_pipe.sv
// Directed bench for cond_addsub_pipe; a wrap-mode and a saturate-mode
// instance receive identical stimulus and are checked side by side.
module tb_cond_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_ready = 1'b0;
    logic        clr_sticky = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    cond_addsub_pipe_if #(.WIDTH(32)) bw ();
    cond_addsub_pipe_if #(.WIDTH(32)) bs ();

    assign bw.in_valid = in_valid;   assign bs.in_valid = in_valid;
    assign bw.a = a;                 assign bs.a = a;
    assign bw.b = b;                 assign bs.b = b;
    assign bw.out_ready = out_ready; assign bs.out_ready = out_ready;
    assign bw.clr_sticky = clr_sticky; assign bs.clr_sticky = clr_sticky;

    cond_addsub_pipe #(.WIDTH(32), .A_MIN(2), .B_MAX(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .bus(bw));
    cond_addsub_pipe #(.WIDTH(32), .A_MIN(2), .B_MAX(10), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair, wait the two-cycle latency; leaves the result presented.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bw.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bw.in_ready); else n_pass++;
        n_checks++; if (bw.out_valid !== 1'b0 || bs.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b/%b want 0/0", bw.out_valid, bs.out_valid); else n_pass++;
        n_checks++; if (bw.sum !== 32'd0 || bw.sub_sel !== 1'b0 || bw.ovf !== 1'b0) $display("FAIL rst_data: got sum=%h sub=%b ovf=%b want 0", bw.sum, bw.sub_sel, bw.ovf); else n_pass++;
        n_checks++; if (bw.ovf_sticky !== 1'b0 || bw.op_count !== 32'd0) $display("FAIL rst_status: got sticky=%b cnt=%0d want 0", bw.ovf_sticky, bw.op_count); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (bw.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", bw.in_ready); else n_pass++;
        exp_cnt = 0;
    endtask

    task automatic test_add();
        issue(32'd5, 32'd3);
        n_checks++; if (bw.out_valid !== 1'b1 || bw.sum !== 32'd8 || bw.sub_sel !== 1'b0 || bw.ovf !== 1'b0)
            $display("FAIL add_5_3: got v=%b sum=%0d sub=%b ovf=%b want 1/8/0/0", bw.out_valid, bw.sum, bw.sub_sel, bw.ovf); else n_pass++;
        tick(); exp_cnt++;
        n_checks++; if (bw.op_count !== 32'(exp_cnt) || bw.out_valid !== 1'b0) $display("FAIL add_count: got cnt=%0d v=%b want %0d/0", bw.op_count, bw.out_valid, exp_cnt); else n_pass++;
        issue(32'd2, 32'd10);
        n_checks++; if (bw.sum !== 32'd12 || bw.sub_sel !== 1'b0) $display("FAIL add_boundary: got sum=%0d sub=%b want 12/0", bw.sum, bw.sub_sel); else n_pass++;
        tick(); exp_cnt++;
    endtask

    task automatic test_sub();
        issue(32'd1, 32'd3);
        n_checks++; if (bw.sum !== 32'hFFFF_FFFE || bw.sub_sel !== 1'b1 || bw.ovf !== 1'b1)
            $display("FAIL sub_wrap: got sum=%h sub=%b ovf=%b want fffffffe/1/1", bw.sum, bw.sub_sel, bw.ovf); else n_pass++;
        n_checks++; if (bs.sum !== 32'd0 || bs.ovf !== 1'b1) $display("FAIL sub_sat: got sum=%h ovf=%b want 0/1", bs.sum, bs.ovf); else n_pass++;
        tick(); exp_cnt++;
        n_checks++; if (bw.ovf_sticky !== 1'b1 || bs.ovf_sticky !== 1'b1) $display("FAIL sub_sticky: got %b/%b want 1/1", bw.ovf_sticky, bs.ovf_sticky); else n_pass++;
        issue(32'd20, 32'd11);
        n_checks++; if (bw.sum !== 32'd9 || bw.sub_sel !== 1'b1 || bw.ovf !== 1'b0) $display("FAIL sub_b_over: got sum=%0d sub=%b ovf=%b want 9/1/0", bw.sum, bw.sub_sel, bw.ovf); else n_pass++;
        tick(); exp_cnt++;
    endtask

    task automatic test_add_ovf();
        issue(32'hFFFF_FFFF, 32'd1);
        n_checks++; if (bw.sum !== 32'd0 || bw.ovf !== 1'b1 || bw.sub_sel !== 1'b0) $display("FAIL add_ovf_wrap: got sum=%h ovf=%b sub=%b want 0/1/0", bw.sum, bw.ovf, bw.sub_sel); else n_pass++;
        n_checks++; if (bs.sum !== 32'hFFFF_FFFF || bs.ovf !== 1'b1) $display("FAIL add_ovf_sat: got sum=%h ovf=%b want ffffffff/1", bs.sum, bs.ovf); else n_pass++;
        tick(); exp_cnt++;
        n_checks++; if (bw.op_count !== 32'(exp_cnt)) $display("FAIL ovf_count: got %0d want %0d", bw.op_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_sticky();
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        n_checks++; if (bw.ovf_sticky !== 1'b0) $display("FAIL sticky_clear: got %b want 0", bw.ovf_sticky); else n_pass++;
        issue(32'd1, 32'd3);
        clr_sticky = 1'b1;
        tick(); exp_cnt++;
        clr_sticky = 1'b0;
        n_checks++; if (bw.ovf_sticky !== 1'b1) $display("FAIL sticky_set_wins: got %b want 1", bw.ovf_sticky); else n_pass++;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        n_checks++; if (bw.ovf_sticky !== 1'b0) $display("FAIL sticky_clear2: got %b want 0", bw.ovf_sticky); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_sum [3];
        exp_sum[0] = 32'd11; exp_sum[1] = 32'd13; exp_sum[2] = 32'd15;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            a = 32'(10 + i); b = 32'(1 + i);
            #1;
            if (i < 3) begin
                n_checks++; if (bw.in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, bw.in_ready); else n_pass++;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                n_checks++; if (bw.out_valid !== 1'b1 || bw.sum !== exp_sum[i-1]) $display("FAIL b2b_out[%0d]: got v=%b sum=%0d want 1/%0d", i-1, bw.out_valid, bw.sum, exp_sum[i-1]); else n_pass++;
                exp_cnt++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (bw.out_valid !== 1'b0 || bw.op_count !== 32'(exp_cnt)) $display("FAIL b2b_drain: got v=%b cnt=%0d want 0/%0d", bw.out_valid, bw.op_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base;
        base = exp_cnt;
        out_ready = 1'b0;
        a = 32'd2; b = 32'd2; in_valid = 1'b1;
        tick();
        a = 32'd3; b = 32'd3;
        tick();
        a = 32'd4; b = 32'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bw.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bw.in_ready); else n_pass++;
            n_checks++; if (bw.out_valid !== 1'b1 || bw.sum !== 32'd4) $display("FAIL bp_hold[%0d]: got v=%b sum=%0d want 1/4", i, bw.out_valid, bw.sum); else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (bw.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bw.in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (bw.sum !== 32'd6 || bw.out_valid !== 1'b1) $display("FAIL bp_out2: got v=%b sum=%0d want 1/6", bw.out_valid, bw.sum); else n_pass++;
        tick();
        n_checks++; if (bw.sum !== 32'd8 || bw.out_valid !== 1'b1) $display("FAIL bp_out3: got v=%b sum=%0d want 1/8", bw.out_valid, bw.sum); else n_pass++;
        tick();
        exp_cnt = base + 3;
        n_checks++; if (bw.out_valid !== 1'b0 || bw.op_count !== 32'(exp_cnt)) $display("FAIL bp_count: got v=%b cnt=%0d want 0/%0d", bw.out_valid, bw.op_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        a = 32'd5; b = 32'd3; in_valid = 1'b1;
        tick();
        a = 32'd6; b = 32'd3;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (bw.in_ready !== 1'b0) $display("FAIL mr_in_ready: got %b want 0", bw.in_ready); else n_pass++;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        n_checks++; if (bw.out_valid !== 1'b0 || bw.op_count !== 32'd0 || bw.sum !== 32'd0) $display("FAIL mr_state: got v=%b cnt=%0d sum=%0d want 0/0/0", bw.out_valid, bw.op_count, bw.sum); else n_pass++;
        tick();
        n_checks++; if (bw.out_valid !== 1'b0) $display("FAIL mr_stale: got v=%b want 0", bw.out_valid); else n_pass++;
        issue(32'd7, 32'd1);
        n_checks++; if (bw.out_valid !== 1'b1 || bw.sum !== 32'd8) $display("FAIL mr_new: got v=%b sum=%0d want 1/8", bw.out_valid, bw.sum); else n_pass++;
        tick(); exp_cnt++;
        n_checks++; if (bw.op_count !== 32'(exp_cnt) || bs.op_count !== 32'(exp_cnt)) $display("FAIL mr_count: got %0d/%0d want %0d", bw.op_count, bs.op_count, exp_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_add_ovf();
        test_sticky();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cond_addsub_pipe.md
Name: cond_addsub_pipe

Overview:
Parametrised, pipelined successor to the combinational conditional add/subtract unit. Takes operand pairs over a valid/ready stream. Per pair it selects a+b or a−b from a threshold predicate, then delivers the result two cycles later with overflow flags. Sits between the operand source and the post-processing blackbox stage. Provides full throughput, backpressure, optional saturation, and an operation counter.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
A_MIN, 2, add-path lower bound on a (unsigned)
B_MAX, 10, add-path upper bound on b (unsigned)
SATURATE, 0, 0 = wrap-around arithmetic, 1 = clamp to [0, 2^WIDTH−1]

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair this cycle
a  input  WIDTH  operand a, unsigned
b  input  WIDTH  operand b, unsigned
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
sub_sel  output  1  1 = result is a−b, 0 = a+b
ovf  output  1  carry-out (add) or borrow (sub) for this result
ovf_sticky  output  1  latched OR of ovf over accepted results
clr_sticky  input  1  clears ovf_sticky
op_count  output  32  number of results accepted downstream

Behaviour:
- Predicate, unsigned: add when (a ≥ A_MIN) && (b ≤ B_MAX || a == 0); otherwise subtract. Evaluated on the accepted input cycle.
- Stage 1 registers a, b and the predicate. Stage 2 computes a WIDTH+1-bit add/sub and registers sum, sub_sel and ovf.
- Latency: input handshake at cycle N → out_valid at N+2 when no backpressure. Throughput is 1 pair/cycle.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_en = !s2_valid || out_ready.
  - in_ready = !rst && (!s1_valid || s2_en); it is combinational and has no dependency on in_valid.
- Output stability: while out_valid && !out_ready, sum, sub_sel and ovf hold stable.
- Ordering: results are in strict input order. No drop, no duplication.
- Wrap mode (SATURATE=0): sum = low WIDTH bits. ovf = bit WIDTH of the add, or (a < b) for subtract.
- Saturate mode (SATURATE=1): add overflow gives sum = all-ones; subtract underflow gives sum = 0. ovf is still reported.
- ovf_sticky:
  - Set on an output transfer with ovf=1.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- op_count: +1 per output transfer, wraps 2^32−1 → 0.
- Reset, any cycle:
  - Both stage valids clear, in-flight pairs are discarded, in_ready = 0 while rst is high.
  - out_valid = 0, sum = 0, sub_sel = 0, ovf = 0, ovf_sticky = 0, op_count = 0.
  - First accept is possible in the cycle after rst deasserts.
- Pipeline full: both stages hold data and out_ready = 0 → in_ready = 0. When out_ready rises, in_ready rises in the same cycle.

Test Plan:
- Add path: a=5, b=3, out_ready=1 → 2 cycles later sum=8, sub_sel=0, ovf=0, op_count=1.
- Subtract path in wrap mode: a=1, b=3 → sum=0xFFFFFFFE, sub_sel=1, ovf=1, ovf_sticky=1. Repeat with SATURATE=1 → sum=0, ovf=1.
- Add overflow: a=0xFFFFFFFF, b=1 → wrap gives sum=0, ovf=1; SATURATE=1 gives sum=0xFFFFFFFF. Also b=11, a=20 → sub, sum=9, ovf=0.
- Backpressure: stream (2,2), (3,3), (4,4) with out_ready=0 for 5 cycles → in_ready drops after 2 accepts. Outputs 4, 6, 8 appear in order. sum is held stable while stalled. op_count=3.
- Sticky clear: clr_sticky pulsed in the same cycle as an ovf=1 output transfer → ovf_sticky stays 1. Next clr_sticky alone → 0.
- Mid-flight reset: 2 pairs in flight, rst high 1 cycle → out_valid=0, op_count=0, no stale result emerges. A new pair (7,1) yields sum=8 two cycles after its accept.
